ts_packet_switch: RTL and testbench
===================================

// Module: ts_packet_switch
// PURPOSE
//  N-channel MPEG2-TS selector with packet-aligned switching and an output FIFO.
//  It switches channels only on 188-byte packet boundaries, so a channel change never splices packets.
//  It checks the packet framing with a byte counter and reports sync errors and FIFO overflow.
//  It sits between the per-channel TS inputs and the QoS output stage, in a single clock domain.
// PARAMETERS
//  NUM_CH      4    number of input channels (>=2); SEL_W = $clog2(NUM_CH) (localparam)
//  DATA_WIDTH  8    TS byte width
//  ADDR_WIDTH  4    FIFO address width; depth = 2**ADDR_WIDTH entries of {sync,data}
//  PKT_LEN     188  bytes per TS packet
// PORTS
//  clk         in   1                    system clock
//  rst         in   1                    synchronous reset, active-high
//  sel_req     in   SEL_W                requested channel; sampled only at packet boundaries
//  data_in     in   NUM_CH*DATA_WIDTH    channel k byte = data_in[k*DATA_WIDTH +: DATA_WIDTH]
//  valid_in    in   NUM_CH               per-channel byte valid
//  sync_in     in   NUM_CH               per-channel first-byte-of-packet flag (qualified by valid)
//  out_ready   in   1                    downstream accepts out_data this cycle
//  out_data    out  DATA_WIDTH           FIFO head byte
//  out_sync    out  1                    FIFO head is a packet start
//  out_valid   out  1                    FIFO non-empty
//  sel_active  out  SEL_W                channel currently being forwarded
//  fifo_level  out  ADDR_WIDTH+1         entries held, 0..DEPTH
//  sync_err    out  1                    1-cycle pulse on a framing error
//  overflow    out  1                    1-cycle pulse when a byte is dropped because the FIFO is full
// BEHAVIOUR
//  Reset: all outputs 0; state HUNT; sel_active 0; byte count 0; FIFO empty.
//  Let v/s/d denote valid/sync/data of channel sel_active. Only that channel is observed.
//  HUNT:
//   - v&!s bytes are discarded.
//   - v&s: push the byte, set cnt=1, go to PASS.
//  PASS, on each v:
//   - !s and cnt<PKT_LEN: push, cnt++.
//   - s and cnt<PKT_LEN (early sync): sync_err pulse; push as a new packet start; cnt=1.
//  PASS, boundary (cnt==PKT_LEN), evaluated in the cycle the last byte is pushed:
//   - If sel_req!=sel_active: sel_active<=sel_req next cycle, cnt=0, go to HUNT.
//   - Otherwise stay in PASS. The next v byte must have s:
//     - s: push, cnt=1.
//     - !s: sync_err pulse, byte discarded, go to HUNT.
//  sel_req >= NUM_CH: treated as "no change".
//  Overflow (push attempted while full):
//   - Byte dropped, overflow pulse, cnt=0, go to HUNT.
//   - The rest of the packet is lost; the next packet starts clean.
//  A cycle with !v changes no state.
//  FIFO behaviour:
//   - First-word-fall-through. Pop occurs when out_valid&out_ready.
//   - A pushed byte is visible on the outputs on the next cycle (1-cycle latency).
//   - full = (level==DEPTH). A push while full is refused even if a pop occurs the same cycle.
//   - Push and pop in the same cycle when not full: level unchanged.
//   - Pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH.
//   - When out_ready=0, the outputs hold stable.
//  Reset mid-packet: the FIFO is flushed, the partial packet is lost, and the block re-hunts on channel 0.
// TESTING
//  1. Channel 0 streams 3 packets (0x47 + 187 bytes), out_ready=1 -> 564 bytes out in order; out_sync on bytes 0,188,376; no pulses.
//  2. sel_req changes 0->2 at byte 50 of a ch0 packet -> ch0 packet completes (188 bytes); sel_active=2 the cycle after; ch2 data starts at its next sync.
//  3. Channel 1 selected, first 10 bytes without sync, then a packet -> the 10 bytes are discarded; output starts with 0x47, out_sync=1.
//  4. Sync arrives at byte 100 of a packet -> sync_err pulse of 1 cycle; that byte is output with out_sync=1; the count restarts.
//  5. out_ready=0, DEPTH=16, a packet arrives -> level reaches 16; the 17th byte gives an overflow pulse; HUNT; after draining, the next packet is whole.
//  6. Full FIFO with simultaneous pop and valid byte -> level 16->15; overflow pulse; rst asserted mid-packet -> level 0, out_valid 0, sel_active 0 next cycle.

Source files
------------

// File: rtl/ts_packet_switch.sv
// N-channel MPEG2-TS selector: forwards one channel, switches only on 188-byte packet boundaries,
// checks framing with a byte counter, and buffers output in a first-word-fall-through FIFO.
module ts_packet_switch #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int PKT_LEN    = 188
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(NUM_CH)-1:0]    sel_req,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            valid_in,
  input  logic [NUM_CH-1:0]            sync_in,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_sync,
  output logic                         out_valid,
  output logic [$clog2(NUM_CH)-1:0]    sel_active,
  output logic [ADDR_WIDTH:0]          fifo_level,
  output logic                         sync_err,
  output logic                         overflow
);

  localparam int SEL_W = $clog2(NUM_CH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(PKT_LEN + 1);
  localparam logic [CNT_W-1:0] PKT_LEN_C = CNT_W'(PKT_LEN);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  // Bit k set when channel index k exists; requests for missing channels are ignored.
  localparam logic [(2**SEL_W)-1:0] CH_OK = {(2**SEL_W){1'b1}} >> ((2**SEL_W) - NUM_CH);

  typedef enum logic {HUNT, PASS} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [SEL_W-1:0]       sel_nxt;
  logic                   sync_err_nxt, overflow_nxt;
  logic                   push, push_ok, pop, full;
  logic                   v, s;
  logic [DATA_WIDTH-1:0]  d;

  logic [DATA_WIDTH:0]    mem [DEPTH];
  logic [ADDR_WIDTH:0]    wptr, rptr;
  logic [DATA_WIDTH:0]    head;

  assign v = valid_in[sel_active];
  assign s = sync_in[sel_active];
  assign d = data_in[int'(sel_active) * DATA_WIDTH +: DATA_WIDTH];

  assign fifo_level = wptr - rptr;
  assign full       = (fifo_level == DEPTH_C);
  assign out_valid  = (fifo_level != '0);
  assign pop        = out_valid & out_ready;
  assign push_ok    = push & ~full;
  assign head       = mem[rptr[ADDR_WIDTH-1:0]];
  assign out_data   = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_sync   = out_valid & head[DATA_WIDTH];

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sel_nxt      = sel_active;
    push         = 1'b0;
    sync_err_nxt = 1'b0;
    overflow_nxt = 1'b0;
    if (v) begin
      case (state)
        HUNT: push = s;
        PASS: begin
          if (cnt == PKT_LEN_C) begin
            push = s;
            if (!s) begin
              sync_err_nxt = 1'b1;
              state_nxt    = HUNT;
              cnt_nxt      = '0;
            end
          end else begin
            push         = 1'b1;
            sync_err_nxt = s;
          end
        end
        default: state_nxt = HUNT;
      endcase
      if (push) begin
        if (full) begin
          overflow_nxt = 1'b1;
          state_nxt    = HUNT;
          cnt_nxt      = '0;
        end else begin
          cnt_nxt   = s ? CNT_W'(1) : cnt + CNT_W'(1);
          state_nxt = PASS;
          // Channel change is decided as the last byte of a packet goes in.
          if (cnt_nxt == PKT_LEN_C && CH_OK[sel_req] && sel_req != sel_active) begin
            sel_nxt   = sel_req;
            cnt_nxt   = '0;
            state_nxt = HUNT;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      cnt        <= '0;
      sel_active <= '0;
      sync_err   <= 1'b0;
      overflow   <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel_active <= sel_nxt;
      sync_err   <= sync_err_nxt;
      overflow   <= overflow_nxt;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wptr[ADDR_WIDTH-1:0]] <= {s, d};
  end

endmodule

// File: tb/tb_ts_packet_switch.sv
// Directed bench for ts_packet_switch: stimulus queues expected {sync,data} bytes, a forked
// monitor pops and compares them as the DUT delivers; pulses and levels checked at fixed points.
module tb_ts_packet_switch;
  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int PKT    = 188;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           sel_req;
  logic [NUM_CH*DW-1:0] data_in;
  logic [NUM_CH-1:0]    valid_in;
  logic [NUM_CH-1:0]    sync_in;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic                 out_sync;
  logic                 out_valid;
  logic [1:0]           sel_active;
  logic [AW:0]          fifo_level;
  logic                 sync_err;
  logic                 overflow;

  int vectors     = 0;
  int miscompares = 0;
  int err_seen    = 0;
  int ovf_seen    = 0;
  logic [8:0] exp_q[$];

  ts_packet_switch #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PKT_LEN(PKT)) dut (
    .clk(clk), .rst(rst), .sel_req(sel_req), .data_in(data_in), .valid_in(valid_in),
    .sync_in(sync_in), .out_ready(out_ready), .out_data(out_data), .out_sync(out_sync),
    .out_valid(out_valid), .sel_active(sel_active), .fifo_level(fifo_level),
    .sync_err(sync_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pb(int base, int i);
    return (i == 0) ? 8'h47 : 8'(base + i);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int ch, bit s, logic [7:0] d);
    valid_in = '0;
    sync_in  = '0;
    data_in  = '0;
    valid_in[ch] = 1'b1;
    sync_in[ch]  = s;
    data_in[ch*DW +: DW] = d;
    tick();
  endtask

  task automatic idle();
    valid_in = '0;
    sync_in  = '0;
    data_in  = '0;
    tick();
  endtask

  task automatic send_pkt(int ch, int base, bit exp_out);
    for (int i = 0; i < PKT; i++) begin
      if (exp_out) exp_q.push_back({1'(i == 0), pb(base, i)});
      drive(ch, i == 0, pb(base, i));
    end
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) idle();
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_level0"}, 32'(fifo_level), 0);
  endtask

  initial begin
    rst = 1'b1; sel_req = 2'd0; data_in = '0; valid_in = '0; sync_in = '0; out_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (sync_err) err_seen++;
          if (overflow) ovf_seen++;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL extra_byte: got sync=%0b data=0x%0h, want nothing", out_sync, out_data);
            end else begin
              chk("out_byte", 32'({out_sync, out_data}), 32'(exp_q.pop_front()));
            end
          end
        end
      end
    join_none

    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_sel_active", 32'(sel_active), 0);
    chk("rst_out_data", 32'({out_sync, out_data}), 0);
    chk("rst_pulses", 32'({sync_err, overflow}), 0);
    rst = 1'b0;
    out_ready = 1'b1;

    // 1: three back-to-back packets on channel 0
    for (int p = 0; p < 3; p++) send_pkt(0, p * 7, 1'b1);
    drain("t1");
    chk("t1_sync_err", err_seen, 0);
    chk("t1_overflow", ovf_seen, 0);

    // 2: switch request mid-packet takes effect only at the boundary
    for (int i = 0; i < PKT; i++) begin
      if (i == 50) sel_req = 2'd2;
      if (i == PKT - 1) chk("t2_sel_before_end", 32'(sel_active), 0);
      exp_q.push_back({1'(i == 0), pb(90, i)});
      drive(0, i == 0, pb(90, i));
    end
    chk("t2_sel_after_end", 32'(sel_active), 2);
    drive(0, 1'b1, 8'h47);
    for (int i = 0; i < 3; i++) drive(2, 1'b0, 8'hE0 + 8'(i));
    send_pkt(2, 20, 1'b1);
    drain("t2");

    // 3: hunt on channel 1 discards bytes until a sync
    sel_req = 2'd1;
    send_pkt(2, 33, 1'b1);
    chk("t3_sel", 32'(sel_active), 1);
    for (int i = 0; i < 10; i++) drive(1, 1'b0, 8'h10 + 8'(i));
    send_pkt(1, 55, 1'b1);
    drain("t3");
    chk("t3_sync_err", err_seen, 0);

    // 4: early sync at byte 100, then a missing sync at the boundary
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back({1'(i == 0), pb(40, i)});
      drive(1, i == 0, pb(40, i));
    end
    exp_q.push_back({1'b1, 8'h47});
    drive(1, 1'b1, 8'h47);
    chk("t4_early_pulse", 32'(sync_err), 1);
    for (int i = 1; i < PKT; i++) begin
      exp_q.push_back({1'b0, pb(70, i)});
      drive(1, 1'b0, pb(70, i));
      if (i == 1) chk("t4_pulse_width", 32'(sync_err), 0);
    end
    drive(1, 1'b0, 8'hAA);
    chk("t4_boundary_pulse", 32'(sync_err), 1);
    drive(1, 1'b0, 8'hAB);
    drive(1, 1'b0, 8'hAC);
    send_pkt(1, 11, 1'b1);
    drain("t4");
    chk("t4_err_count", err_seen, 2);

    // 5: stalled output fills the FIFO; the 17th byte overflows
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({1'(i == 0), pb(3, i)});
      drive(1, i == 0, pb(3, i));
    end
    chk("t5_level_full", 32'(fifo_level), 16);
    chk("t5_head", 32'({out_sync, out_data}), 32'h147);
    drive(1, 1'b0, pb(3, 16));
    chk("t5_ovf_pulse", 32'(overflow), 1);
    chk("t5_level_held", 32'(fifo_level), 16);
    for (int i = 17; i < PKT; i++) drive(1, 1'b0, pb(3, i));
    chk("t5_head_stable", 32'({out_sync, out_data}), 32'h147);
    out_ready = 1'b1;
    drain("t5a");
    send_pkt(1, 77, 1'b1);
    drain("t5b");
    chk("t5_ovf_count", ovf_seen, 1);

    // 6: pop and refused push in the same cycle, then reset mid-packet
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({1'(i == 0), pb(120, i)});
      drive(1, i == 0, pb(120, i));
    end
    out_ready = 1'b1;
    drive(1, 1'b0, pb(120, 16));
    out_ready = 1'b0;
    chk("t6_level_15", 32'(fifo_level), 15);
    chk("t6_ovf_pulse", 32'(overflow), 1);
    drive(1, 1'b0, pb(120, 17));
    rst = 1'b1;
    exp_q.delete();
    idle();
    chk("t6_rst_level", 32'(fifo_level), 0);
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_sel", 32'(sel_active), 0);
    rst = 1'b0;
    sel_req = 2'd0;
    out_ready = 1'b1;
    send_pkt(0, 200, 1'b1);
    drain("t6");
    chk("t6_ovf_count", ovf_seen, 2);
    chk("t6_err_count", err_seen, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
